rc4_swap_engine: RTL and testbench



---
 rtl/rc4_swap_engine.sv | 202 ++++++++++++++++++++
 tb/tb_rc4_swap_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_swap_engine.sv
// Purpose: swaps S[i] and S[j] in place on an external single-port S-box RAM with a
//          read-modify-write sequence, optionally reading S[(S[i]+S[j]) mod 2^AW].
// Latency: start accept -> done = 2*(RD_WAIT+1)+3 cycles, or 3*(RD_WAIT+1)+3 with fetch_k.
// Backpressure: start is only sampled in IDLE; requests made while busy are dropped.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, i_idx, j_idx,  request pulse plus operands, captured when start is accepted
//   fetch_k
//   busy, done            busy = not IDLE; done = single-cycle completion pulse
//   si_out, sj_out        original S[i] / S[j], held from done until the next accepted start
//   k_out                 keystream byte when fetch_k was set, otherwise 0
//   mem_addr, mem_wdata,  registered RAM command port, owned by this block while busy
//   mem_wren
//   mem_rdata             RAM read data
module rc4_swap_engine #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int RD_WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] i_idx,
  input  logic [AW-1:0] j_idx,
  input  logic          fetch_k,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] si_out,
  output logic [DW-1:0] sj_out,
  output logic [DW-1:0] k_out,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_rdata
);

  // Wait counter only needs to reach RD_WAIT; keep at least one bit for RD_WAIT = 0.
  localparam int            CW        = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(RD_WAIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_I,
    ST_RD_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_K,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic          fk_q, fk_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0] si_q, si_d;
  logic [DW-1:0] sj_q, sj_d;
  logic [DW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wren_q, wren_d;

  logic          rd_last;
  logic [AW-1:0] k_addr;

  // The RAM port is registered, so every command is computed one cycle ahead:
  // the values loaded on a state transition are what the RAM sees during the
  // first cycle of the new state.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    fk_d    = fk_q;
    wcnt_d  = wcnt_q;
    si_d    = si_q;
    sj_d    = sj_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;

    rd_last = (wcnt_q == WAIT_LAST);
    // Casting each operand to AW bits first makes the sum wrap modulo 2^AW.
    k_addr  = AW'(si_q) + AW'(sj_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = i_idx;
          j_d     = j_idx;
          fk_d    = fetch_k;
          k_d     = '0;
          wcnt_d  = '0;
          addr_d  = i_idx;
          state_d = ST_RD_I;
        end
      end

      ST_RD_I: begin
        if (rd_last) begin
          si_d    = mem_rdata;
          wcnt_d  = '0;
          addr_d  = j_q;
          state_d = ST_RD_J;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end

      ST_RD_J: begin
        if (rd_last) begin
          sj_d    = mem_rdata;
          wcnt_d  = '0;
          // S[j] is being captured on this same edge, so forward it straight
          // into the write data for S[i].
          addr_d  = i_q;
          wdata_d = mem_rdata;
          wren_d  = 1'b1;
          state_d = ST_WR_I;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end

      ST_WR_I: begin
        addr_d  = j_q;
        wdata_d = si_q;
        wren_d  = 1'b1;
        state_d = ST_WR_J;
      end

      ST_WR_J: begin
        if (fk_q) begin
          // Reading after the writes is safe: S[i]+S[j] is symmetric.
          addr_d  = k_addr;
          wcnt_d  = '0;
          state_d = ST_RD_K;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_RD_K: begin
        if (rd_last) begin
          k_d     = mem_rdata;
          wcnt_d  = '0;
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      fk_q    <= 1'b0;
      wcnt_q  <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      fk_q    <= fk_d;
      wcnt_q  <= wcnt_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
    end
  end

  // Decoded straight from the state flop so reset clears them without a clock.
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign si_out    = si_q;
  assign sj_out    = sj_q;
  assign k_out     = k_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wren  = wren_q;

endmodule

// File: tb/tb_rc4_swap_engine.sv
// Bench for rc4_swap_engine: one instance on a registered-address RAM (RD_WAIT=1)
// and one on a two-stage RAM (RD_WAIT=2). Directed table vectors plus hand
// sequences for ignored start, held start and mid-transaction reset.
module tb_rc4_swap_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       start1, fk1, busy1, done1, wren1, load1;
  logic [7:0] i1, j1, si1, sj1, k1, addr1, wdata1, rdata1, ra1;
  logic       start2, fk2, busy2, done2, wren2, load2;
  logic [7:0] i2, j2, si2, sj2, k2, addr2, wdata2, rdata2, ra2, rq2;

  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];

  rc4_swap_engine #(.DW(8), .AW(8), .RD_WAIT(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .i_idx(i1), .j_idx(j1), .fetch_k(fk1),
    .busy(busy1), .done(done1), .si_out(si1), .sj_out(sj1), .k_out(k1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_wren(wren1), .mem_rdata(rdata1)
  );

  rc4_swap_engine #(.DW(8), .AW(8), .RD_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .i_idx(i2), .j_idx(j2), .fetch_k(fk2),
    .busy(busy2), .done(done2), .si_out(si2), .sj_out(sj2), .k_out(k2),
    .mem_addr(addr2), .mem_wdata(wdata2), .mem_wren(wren2), .mem_rdata(rdata2)
  );

  // Registered address, unregistered q.
  always @(posedge clk) begin
    if (load1) for (int n = 0; n < 256; n++) mem1[n] <= 8'(n);
    else if (wren1) mem1[addr1] <= wdata1;
    ra1 <= addr1;
  end
  assign rdata1 = mem1[ra1];

  // Registered address and registered q: two cycles of read latency.
  always @(posedge clk) begin
    if (load2) for (int n = 0; n < 256; n++) mem2[n] <= 8'(n);
    else if (wren2) mem2[addr2] <= wdata2;
    ra2 <= addr2;
    rq2 <= mem2[ra2];
  end
  assign rdata2 = rq2;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic preload(input bit sel);
    @(negedge clk);
    if (sel) load2 = 1'b1; else load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    load2 = 1'b0;
  endtask

  // Issue one request and watch 30 cycles. Cycle 1 is the cycle after the
  // accepting edge; lat is the cycle in which done is first seen (-1 if never).
  task automatic run_txn(input bit sel, input logic [7:0] i, input logic [7:0] j,
                         input bit fk, output int lat, output int wrens,
                         output int dones, output int busy_after);
    lat = -1; wrens = 0; dones = 0; busy_after = -1;
    @(negedge clk);
    if (sel) begin start2 = 1'b1; i2 = i; j2 = j; fk2 = fk; end
    else     begin start1 = 1'b1; i1 = i; j1 = j; fk1 = fk; end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin start1 = 1'b0; start2 = 1'b0; end
      if (lat > 0 && c == lat + 1) busy_after = int'(sel ? busy2 : busy1);
      if (sel ? wren2 : wren1) wrens++;
      if (sel ? done2 : done1) begin
        dones++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  typedef struct {
    logic [7:0] i;
    logic [7:0] j;
    bit         fk;
    int         lat;
    int         si;
    int         sj;
    int         k;
    int         ndiff;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wrens, dones, busy_after, d, d1, d2, nd, s2si, s2sj;

    // Identity preload before each vector; k_out must be cleared by the fetch_k=0
    // vector that follows a fetch_k=1 one.
    tbl[0] = '{i: 8'd10,  j: 8'd20,  fk: 1'b1, lat: 9, si: 10,  sj: 20,  k: 30,  ndiff: 2};
    tbl[1] = '{i: 8'd3,   j: 8'd200, fk: 1'b0, lat: 7, si: 3,   sj: 200, k: 0,   ndiff: 2};
    tbl[2] = '{i: 8'd250, j: 8'd251, fk: 1'b1, lat: 9, si: 250, sj: 251, k: 245, ndiff: 2};
    tbl[3] = '{i: 8'd77,  j: 8'd77,  fk: 1'b0, lat: 7, si: 77,  sj: 77,  k: 0,   ndiff: 0};

    reset = 1'b1;
    start1 = 1'b0; i1 = '0; j1 = '0; fk1 = 1'b0; load1 = 1'b0;
    start2 = 1'b0; i2 = '0; j2 = '0; fk2 = 1'b0; load2 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",  int'(busy1),  0);
    chk("rst_done",  int'(done1),  0);
    chk("rst_wren",  int'(wren1),  0);
    chk("rst_addr",  int'(addr1),  0);
    chk("rst_wdata", int'(wdata1), 0);
    chk("rst_si",    int'(si1),    0);
    chk("rst_sj",    int'(sj1),    0);
    chk("rst_k",     int'(k1),     0);
    chk("rst_busy2", int'(busy2),  0);

    for (int v = 0; v < 4; v++) begin
      preload(1'b0);
      run_txn(1'b0, tbl[v].i, tbl[v].j, tbl[v].fk, lat, wrens, dones, busy_after);
      chk($sformatf("v%0d_latency", v), lat, tbl[v].lat);
      chk($sformatf("v%0d_si", v), int'(si1), tbl[v].si);
      chk($sformatf("v%0d_sj", v), int'(sj1), tbl[v].sj);
      chk($sformatf("v%0d_k", v), int'(k1), tbl[v].k);
      chk($sformatf("v%0d_wren_cycles", v), wrens, 2);
      chk($sformatf("v%0d_done_pulses", v), dones, 1);
      chk($sformatf("v%0d_busy_after_done", v), busy_after, 0);
      chk($sformatf("v%0d_mem_i", v), int'(mem1[tbl[v].i]), tbl[v].sj);
      chk($sformatf("v%0d_mem_j", v), int'(mem1[tbl[v].j]), tbl[v].si);
      d = 0;
      for (int n = 0; n < 256; n++) if (int'(mem1[n]) != n) d++;
      chk($sformatf("v%0d_mem_diffs", v), d, tbl[v].ndiff);
    end

    // start pulsed again during RD_J with different indices: must be ignored.
    preload(1'b0);
    @(negedge clk);
    start1 = 1'b1; i1 = 8'd3; j1 = 8'd5; fk1 = 1'b0;
    wrens = 0; dones = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start1 = 1'b0;
      if (c == 3) begin start1 = 1'b1; i1 = 8'd9; j1 = 8'd11; end
      if (c == 4) start1 = 1'b0;
      if (wren1) wrens++;
      if (done1) dones++;
    end
    chk("ign_done_pulses", dones, 1);
    chk("ign_wren_cycles", wrens, 2);
    chk("ign_mem3", int'(mem1[3]), 5);
    chk("ign_mem5", int'(mem1[5]), 3);
    chk("ign_mem9", int'(mem1[9]), 9);
    chk("ign_mem11", int'(mem1[11]), 11);

    // start held high: second swap accepted after one IDLE cycle, undoing the first.
    preload(1'b0);
    d1 = -1; d2 = -1; nd = 0; s2si = -1; s2sj = -1;
    @(negedge clk);
    start1 = 1'b1; i1 = 8'd1; j1 = 8'd2; fk1 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done1) begin
        nd++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) begin d2 = c; s2si = int'(si1); s2sj = int'(sj1); end
      end
      if (c == 10) start1 = 1'b0;
    end
    chk("hold_first_done", d1, 7);
    chk("hold_second_done", d2, 15);
    chk("hold_done_pulses", nd, 2);
    chk("hold_second_si", s2si, 2);
    chk("hold_second_sj", s2sj, 1);
    chk("hold_mem1", int'(mem1[1]), 1);
    chk("hold_mem2", int'(mem1[2]), 2);

    // Reset asserted in WR_I: outputs clear without a clock edge, WR_J never writes.
    preload(1'b0);
    @(negedge clk);
    start1 = 1'b1; i1 = 8'd4; j1 = 8'd6; fk1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start1 = 1'b0;
    end
    chk("rmid_in_wr_i", int'(wren1), 1);
    reset = 1'b1;
    #1;
    chk("rmid_busy", int'(busy1), 0);
    chk("rmid_done", int'(done1), 0);
    chk("rmid_wren", int'(wren1), 0);
    chk("rmid_si", int'(si1), 0);
    chk("rmid_addr", int'(addr1), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_mem6", int'(mem1[6]), 6);
    chk("rmid_mem4", int'(mem1[4]), 4);
    run_txn(1'b0, 8'd4, 8'd6, 1'b0, lat, wrens, dones, busy_after);
    chk("rmid_rerun_latency", lat, 7);
    chk("rmid_rerun_mem4", int'(mem1[4]), 6);
    chk("rmid_rerun_mem6", int'(mem1[6]), 4);

    // RD_WAIT=2 against the two-cycle RAM.
    preload(1'b1);
    run_txn(1'b1, 8'd5, 8'd9, 1'b0, lat, wrens, dones, busy_after);
    chk("w2_latency", lat, 9);
    chk("w2_si", int'(si2), 5);
    chk("w2_sj", int'(sj2), 9);
    chk("w2_wren_cycles", wrens, 2);
    chk("w2_mem5", int'(mem2[5]), 9);
    chk("w2_mem9", int'(mem2[9]), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
